gb_cart_reader: RTL and testbench
=================================

Name: gb_cart_reader

Overview:
- Upstream of the startup screen generator: services its byte-read handshake (rom_addr / rom_rd / rom_bsy / rom_data) by running timed read cycles on the physical Game Boy cartridge bus.
- Drives the cartridge address, /RD and /CS lines from clk_8m with programmable setup, strobe and hold timing.
- Captures the data byte and holds it for the requester.
- Read-only: cart_nwr is held inactive.

Parameters:
- SETUP_CYC, 2, clk_8m cycles address is stable before cart_nrd falls (>=1)
- STROBE_CYC, 4, clk_8m cycles cart_nrd is held low; data sampled on the last one (>=1)
- HOLD_CYC, 1, clk_8m cycles address is held after cart_nrd rises (>=1)

Ports:
- clk_8m  in  1  system clock, 8 MHz
- rst  in  1  reset, asynchronous, active-high
- rom_addr  in  16  byte address; sampled only on the clock edge where rom_rd=1 and engine idle
- rom_rd  in  1  single-cycle read request
- rom_data  out  8  last byte read; stable until the next accepted request completes
- rom_bsy  out  1  high while a request is pending or in progress
- rd_overrun  out  1  sticky: rom_rd seen while engine busy
- cart_a  out  16  cartridge address bus
- cart_d_in  in  8  cartridge data bus (input only)
- cart_nrd  out  1  cartridge /RD, active low
- cart_ncs  out  1  cartridge /CS, active low
- cart_nwr  out  1  cartridge /WR; constant 1

Behaviour:
- Clock/reset: one clock, clk_8m. rst is asynchronous, active-high.
- Reset values: state=IDLE, cart_a=0, cart_nrd=1, cart_ncs=1, rom_data=0, rd_overrun=0, counter=0.
- Reset mid-transaction aborts immediately: /RD and /CS go high asynchronously and no byte is captured.
- Output timing:
  - rom_bsy = (state!=IDLE) | rom_rd, combinational.
  - The requester samples rom_bsy in the same cycle it holds rom_rd, so busy must be visible that cycle.
  - All cart_* outputs are registered (glitch-free).
- FSM states: IDLE, SETUP, STROBE, HOLD. A cycle counter is loaded with the stage length minus 1 on entry to each stage.
- IDLE:
  - On an edge with rom_rd=1: cart_a<=rom_addr; cart_ncs<=0 iff rom_addr>=16'hA000, else 1; go to SETUP.
  - cart_a otherwise keeps its last value.
- SETUP:
  - cart_nrd=1.
  - After SETUP_CYC cycles: cart_nrd<=0, go to STROBE.
- STROBE:
  - cart_nrd=0.
  - On the edge ending the STROBE_CYC-th cycle: rom_data<=cart_d_in, cart_nrd<=1, go to HOLD.
- HOLD:
  - cart_a and cart_ncs held.
  - After HOLD_CYC cycles: cart_ncs<=1, go to IDLE.
- Latency:
  - Request cycle T. Engine is busy for cycles T+1 .. T+SETUP_CYC+STROBE_CYC+HOLD_CYC (defaults: T+1..T+7).
  - First idle cycle is T+8. rom_bsy is low there and rom_data is already valid.
- Protocol violation: rom_rd=1 while state!=IDLE is ignored (no address latch, no restart) and sets rd_overrun=1. Only reset clears rd_overrun.
- Back-to-back requests: rom_rd in the first IDLE cycle is accepted normally. Min request spacing = S+P+H+1 cycles.
- rom_rd held high continuously: one request accepted per idle cycle. Every busy-cycle high sets rd_overrun.
- rom_data is never updated except by a STROBE capture. A request aborted by reset leaves rom_data=0.
- Address wrap: 16'hFFFF is read like any other address. There is no auto-increment.

Test Plan:
- Reset release, then rom_rd pulse with rom_addr=16'h0104, cart_d_in=8'hCE -> rom_bsy high in cycles T..T+7; cart_a=16'h0104 from T+1; cart_nrd low exactly in cycles T+3..T+6; cart_ncs stays 1; rom_data=8'hCE from T+7; rom_bsy low at T+8.
- Read at 16'hA000, cart_d_in=8'h5A -> cart_ncs low in cycles T+1..T+7, high at T+8; rom_data=8'h5A.
- 48 back-to-back reads, addresses 260..307, each issued on the first idle cycle, cart_d_in=addr[7:0] -> every rom_data matches; rd_overrun stays 0; no cart_nrd glitch between transactions.
- rom_rd pulsed at T+3 of an active read with a different address -> cart_a unchanged, transaction completes normally, rd_overrun=1 and remains 1 until rst.
- rst asserted asynchronously mid-STROBE (T+4) -> cart_nrd=1, cart_ncs=1, rom_bsy=0, rom_data=0 immediately, without waiting for a clock edge; a subsequent read works.
- Parameters SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1 -> cart_nrd low only in cycle T+2; rom_data valid and rom_bsy low at T+4.

Source files
------------

// File: rtl/gb_cart_reader.sv
// Game Boy cartridge read engine: turns single-cycle byte requests into
// timed /CS, /RD and address cycles on the cartridge bus.
module gb_cart_reader #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk_8m,
    input  logic        rst,
    input  logic [15:0] rom_addr,
    input  logic        rom_rd,
    output logic [7:0]  rom_data,
    output logic        rom_bsy,
    output logic        rd_overrun,
    output logic [15:0] cart_a,
    input  logic [7:0]  cart_d_in,
    output logic        cart_nrd,
    output logic        cart_ncs,
    output logic        cart_nwr
);

    localparam int MAXC = (SETUP_CYC > STROBE_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] P_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] H_LD = CW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   cart_a_q, cart_a_d;
    logic          nrd_q, nrd_d;
    logic          ncs_q, ncs_d;
    logic [7:0]    data_q, data_d;
    logic          ovr_q, ovr_d;
    logic          last;

    assign last = (cnt_q == '0);

    always_ff @(posedge clk_8m or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cart_a_q <= '0;
            nrd_q    <= 1'b1;
            ncs_q    <= 1'b1;
            data_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cart_a_q <= cart_a_d;
            nrd_q    <= nrd_d;
            ncs_q    <= ncs_d;
            data_q   <= data_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rom_rd) begin
                    state_d = SETUP;
                    cnt_d   = S_LD;
                end
            end
            SETUP: begin
                if (last) begin
                    state_d = STROBE;
                    cnt_d   = P_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                if (last) begin
                    state_d = HOLD;
                    cnt_d   = H_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus outputs are computed one cycle ahead so every cart_* pin is a flop.
    always_comb begin
        cart_a_d = cart_a_q;
        nrd_d    = nrd_q;
        ncs_d    = ncs_q;
        data_d   = data_q;
        ovr_d    = ovr_q | (rom_rd & (state_q != IDLE));
        unique case (state_q)
            IDLE: begin
                nrd_d = 1'b1;
                if (rom_rd) begin
                    cart_a_d = rom_addr;
                    ncs_d    = (rom_addr < 16'hA000);
                end
            end
            SETUP: begin
                nrd_d = ~last;
            end
            STROBE: begin
                nrd_d = last;
                if (last) begin
                    data_d = cart_d_in;
                end
            end
            HOLD: begin
                nrd_d = 1'b1;
                if (last) begin
                    ncs_d = 1'b1;
                end
            end
            default: begin
                nrd_d = 1'b1;
                ncs_d = 1'b1;
            end
        endcase
    end

    assign rom_bsy    = (state_q != IDLE) | rom_rd;
    assign rom_data   = data_q;
    assign rd_overrun = ovr_q;
    assign cart_a     = cart_a_q;
    assign cart_nrd   = nrd_q;
    assign cart_ncs   = ncs_q;
    assign cart_nwr   = 1'b1;

endmodule

// File: tb/tb_gb_cart_reader.sv
// Bench for gb_cart_reader: directed reads with a scoreboard that is
// drained whenever /RD rises at the end of a strobe.
module tb_gb_cart_reader;

    logic        clk_8m = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rom_addr = '0;
    logic        rom_rd = 1'b0;
    logic        rom_rd1 = 1'b0;
    logic [7:0]  cart_d_in = '0;

    logic [7:0]  rom_data, rom_data1;
    logic        rom_bsy, rom_bsy1;
    logic        rd_overrun, rd_overrun1;
    logic [15:0] cart_a, cart_a1;
    logic        cart_nrd, cart_nrd1;
    logic        cart_ncs, cart_ncs1;
    logic        cart_nwr, cart_nwr1;

    gb_cart_reader dut (
        .clk_8m(clk_8m), .rst(rst),
        .rom_addr(rom_addr), .rom_rd(rom_rd),
        .rom_data(rom_data), .rom_bsy(rom_bsy),
        .rd_overrun(rd_overrun), .cart_a(cart_a),
        .cart_d_in(cart_d_in), .cart_nrd(cart_nrd),
        .cart_ncs(cart_ncs), .cart_nwr(cart_nwr)
    );

    gb_cart_reader #(
        .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)
    ) dut1 (
        .clk_8m(clk_8m), .rst(rst),
        .rom_addr(rom_addr), .rom_rd(rom_rd1),
        .rom_data(rom_data1), .rom_bsy(rom_bsy1),
        .rd_overrun(rd_overrun1), .cart_a(cart_a1),
        .cart_d_in(cart_d_in), .cart_nrd(cart_nrd1),
        .cart_ncs(cart_ncs1), .cart_nwr(cart_nwr1)
    );

    always #5 clk_8m = ~clk_8m;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_nrd = 1'b1;
    int   low_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_8m);
        #1;
    endtask

    // One read issued on an idle cycle; returns on the next idle cycle.
    task automatic rd(input logic [15:0] a, input logic [7:0] d);
        chk("idle_before_req", rom_bsy, 0);
        rom_addr  = a;
        cart_d_in = d;
        rom_rd    = 1'b1;
        sb.push_back('{a: a, d: d});
        tick();
        rom_rd = 1'b0;
        repeat (7) tick();
    endtask

    always @(negedge clk_8m) begin
        if (rst) begin
            prev_nrd = 1'b1;
            low_cnt  = 0;
        end else begin
            if (!cart_nrd) begin
                low_cnt++;
            end else if (!prev_nrd) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: read completed, none pending");
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_data", rom_data, mon_e.d);
                    chk("sb_addr", cart_a, mon_e.a);
                    chk("sb_strobe_len", low_cnt, 4);
                end
                low_cnt = 0;
            end
            prev_nrd = cart_nrd;
        end
    end

    initial begin
        repeat (2) @(negedge clk_8m);
        chk("rst_cart_a", cart_a, 0);
        chk("rst_nrd", cart_nrd, 1);
        chk("rst_ncs", cart_ncs, 1);
        chk("rst_data", rom_data, 0);
        chk("rst_ovr", rd_overrun, 0);
        chk("rst_bsy", rom_bsy, 0);
        chk("nwr", cart_nwr, 1);
        tick();
        rst = 1'b0;
        tick();

        // Low ROM read: /CS stays high, /RD low T+3..T+6
        rom_addr  = 16'h0104;
        cart_d_in = 8'hCE;
        rom_rd    = 1'b1;
        sb.push_back('{a: 16'h0104, d: 8'hCE});
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk_8m);
            chk($sformatf("t1_bsy_%0d", k), rom_bsy, (k <= 7) ? 1 : 0);
            chk($sformatf("t1_nrd_%0d", k), cart_nrd,
                (k >= 3 && k <= 6) ? 0 : 1);
            chk($sformatf("t1_ncs_%0d", k), cart_ncs, 1);
            if (k >= 1) chk($sformatf("t1_a_%0d", k), cart_a, 16'h0104);
            if (k >= 7) chk($sformatf("t1_data_%0d", k), rom_data, 8'hCE);
            tick();
            if (k == 0) rom_rd = 1'b0;
        end

        // Cartridge RAM window: /CS low T+1..T+7
        rom_addr  = 16'hA000;
        cart_d_in = 8'h5A;
        rom_rd    = 1'b1;
        sb.push_back('{a: 16'hA000, d: 8'h5A});
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk_8m);
            chk($sformatf("t2_ncs_%0d", k), cart_ncs,
                (k >= 1 && k <= 7) ? 0 : 1);
            if (k >= 7) chk($sformatf("t2_data_%0d", k), rom_data, 8'h5A);
            tick();
            if (k == 0) rom_rd = 1'b0;
        end

        for (int i = 260; i <= 307; i++) begin
            rd(16'(i), 8'(i));
        end
        repeat (2) tick();
        chk("b2b_ovr", rd_overrun, 0);

        // Request during an active read must be ignored
        rom_addr  = 16'h1234;
        cart_d_in = 8'h77;
        rom_rd    = 1'b1;
        sb.push_back('{a: 16'h1234, d: 8'h77});
        tick();
        rom_rd = 1'b0;
        repeat (2) tick();
        rom_addr = 16'h5555;
        rom_rd   = 1'b1;
        tick();
        rom_rd   = 1'b0;
        rom_addr = 16'h0000;
        chk("ovr_cart_a", cart_a, 16'h1234);
        chk("ovr_set", rd_overrun, 1);
        repeat (4) tick();
        rd(16'h4000, 8'h11);
        chk("ovr_sticky", rd_overrun, 1);

        // Asynchronous reset in the middle of the strobe
        rom_addr  = 16'h2000;
        cart_d_in = 8'h99;
        rom_rd    = 1'b1;
        tick();
        rom_rd = 1'b0;
        repeat (3) tick();
        chk("abort_pre_nrd", cart_nrd, 0);
        #2 rst = 1'b1;
        #1;
        chk("abort_nrd", cart_nrd, 1);
        chk("abort_ncs", cart_ncs, 1);
        chk("abort_bsy", rom_bsy, 0);
        chk("abort_data", rom_data, 0);
        chk("abort_ovr", rd_overrun, 0);
        tick();
        rst = 1'b0;
        tick();
        rd(16'hFFFF, 8'hA5);
        chk("wrap_data", rom_data, 8'hA5);

        // Minimum timing instance
        rom_addr  = 16'h0150;
        cart_d_in = 8'h3C;
        rom_rd1   = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk_8m);
            chk($sformatf("p1_bsy_%0d", k), rom_bsy1, (k <= 3) ? 1 : 0);
            chk($sformatf("p1_nrd_%0d", k), cart_nrd1, (k == 2) ? 0 : 1);
            if (k >= 3) chk($sformatf("p1_data_%0d", k), rom_data1, 8'h3C);
            tick();
            if (k == 0) rom_rd1 = 1'b0;
        end

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
